// File: rtl/pkt_framer_tx_if.sv
// Producer-side and link-side signals of the packet framing transmitter.
// master: the framer itself; slave: the producer/receiver pair driving it.
interface pkt_framer_tx_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              tx_ready;
    logic              valid;
    logic              head;
    logic              tail;
    logic [DATA_W-1:0] data;
    logic [15:0]       state;

    modport master (
        input  wr_en, wr_data, start, len, tx_ready,
        output full, busy, valid, head, tail, data, state
    );

    modport slave (
        output wr_en, wr_data, start, len, tx_ready,
        input  full, busy, valid, head, tail, data, state
    );
endinterface

// File: rtl/pkt_framer_tx.sv
// Framing transmitter: HEAD(len), LEN body beats from a FWFT FIFO, TAIL(xor checksum).
// Latency: HEAD valid one cycle after start; L+2 valid cycles per packet at full rate.
// Backpressure: beats hold while tx_ready=0; outputs decode from registers only.
module pkt_framer_tx #(
    parameter int          DATA_W     = 8,
    parameter int          LEN_W      = 4,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] STATE_IDLE = 16'h0001,
    parameter logic [15:0] STATE_HEAD = 16'h0010,
    parameter logic [15:0] STATE_DATA = 16'h0100,
    parameter logic [15:0] STATE_TAIL = 16'h1000
) (
    input  logic           clk,
    input  logic           reset,
    pkt_framer_tx_if.master lnk
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [15:0] {
        ST_IDLE = STATE_IDLE,
        ST_HEAD = STATE_HEAD,
        ST_DATA = STATE_DATA,
        ST_TAIL = STATE_TAIL
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [AW:0]       w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_fifo_word;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] r_csum;
    logic [DATA_W-1:0] w_csum_nxt;
    logic              w_valid;
    logic              w_head;
    logic              w_tail;
    logic [DATA_W-1:0] w_data;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty     = (w_count == '0);
    assign w_fifo_word = r_mem[r_rd_ptr[AW-1:0]];
    assign w_push      = lnk.wr_en & ~w_full;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_csum_nxt  = r_csum;
        w_pop       = 1'b0;
        w_valid     = 1'b0;
        w_head      = 1'b0;
        w_tail      = 1'b0;
        w_data      = '0;
        case (r_state)
            ST_IDLE: begin
                if (lnk.start) begin
                    w_state_nxt = ST_HEAD;
                    w_cnt_nxt   = lnk.len;
                    w_csum_nxt  = '0;
                end
            end
            ST_HEAD: begin
                w_valid = 1'b1;
                w_head  = 1'b1;
                w_data  = DATA_W'(r_cnt);
                if (lnk.tx_ready) begin
                    w_state_nxt = (r_cnt != '0) ? ST_DATA : ST_TAIL;
                end
            end
            ST_DATA: begin
                // An empty FIFO is a stall bubble, not an error.
                w_valid = ~w_empty;
                w_data  = w_empty ? '0 : w_fifo_word;
                if (!w_empty && lnk.tx_ready) begin
                    w_pop      = 1'b1;
                    w_csum_nxt = r_csum ^ w_fifo_word;
                    w_cnt_nxt  = r_cnt - LEN_W'(1);
                    if (r_cnt == LEN_W'(1)) begin
                        w_state_nxt = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                w_valid = 1'b1;
                w_tail  = 1'b1;
                w_data  = r_csum;
                if (lnk.tx_ready) begin
                    if (lnk.start) begin
                        w_state_nxt = ST_HEAD;
                        w_cnt_nxt   = lnk.len;
                        w_csum_nxt  = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_csum   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_csum  <= w_csum_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: the pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= lnk.wr_data;
        end
    end

    assign lnk.full  = w_full;
    assign lnk.busy  = (r_state != ST_IDLE);
    assign lnk.valid = w_valid;
    assign lnk.head  = w_head;
    assign lnk.tail  = w_tail;
    assign lnk.data  = w_data;
    assign lnk.state = r_state;
endmodule

// File: tb/tb_pkt_framer_tx.sv
// Directed bench for pkt_framer_tx: per-cycle stimulus words and hand-computed expected link beats.
// Stim word {rst,rdy,we,st, wr_data[7:0], len[3:0]}; expect word {00,busy,full, state, 0,v,h,t, data}.
module tb_pkt_framer_tx;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pkt_framer_tx_if #(.DATA_W(8), .LEN_W(4)) ifc ();

    pkt_framer_tx #(.DATA_W(8), .LEN_W(4), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .lnk   (ifc)
    );

    // Body data is only meaningful while valid, so it is masked otherwise.
    logic [31:0] w_obs;
    assign w_obs = {2'b00, ifc.busy, ifc.full, ifc.state, 1'b0, ifc.valid, ifc.head, ifc.tail,
                    ifc.valid ? ifc.data : 8'h00};

    task automatic drive(input logic [15:0] s);
        reset        = s[15];
        ifc.tx_ready = s[14];
        ifc.wr_en    = s[13];
        ifc.start    = s[12];
        ifc.wr_data  = s[11:4];
        ifc.len      = s[3:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 7; i++) begin
            drive((i < 2) ? 16'hF0A3 : 16'h4000);
            tick();
            if (w_obs !== 32'h0_0001_0_00 || ifc.data !== 8'h00) begin
                n_err++;
                $display("FAIL reset step %0d: got %h data %h, expected 00001000 data 00", i, w_obs, ifc.data);
            end
            n_vec++;
        end
    endtask

    task automatic test_basic();
        logic [15:0] stim [7];
        logic [31:0] exp [7];
        stim = '{16'h6A50, 16'h63C0, 16'h5002, 16'h4000, 16'h4000, 16'h4000, 16'h4000};
        exp  = '{32'h0_0001_0_00, 32'h0_0001_0_00, 32'h2_0010_6_02, 32'h2_0100_4_A5,
                 32'h2_0100_4_3C, 32'h2_1000_5_99, 32'h0_0001_0_00};
        for (int i = 0; i < 7; i++) begin
            drive(stim[i]);
            tick();
            if (w_obs !== exp[i]) begin
                n_err++;
                $display("FAIL basic step %0d: got %h expected %h", i, w_obs, exp[i]);
            end
            n_vec++;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] stim [12];
        logic [31:0] exp [12];
        stim = '{16'h6110, 16'h5003, 16'h0000, 16'h4000, 16'h0000, 16'h4000,
                 16'h4000, 16'h6220, 16'h6440, 16'h4000, 16'h0000, 16'h4000};
        exp  = '{32'h0_0001_0_00, 32'h2_0010_6_03, 32'h2_0010_6_03, 32'h2_0100_4_11,
                 32'h2_0100_4_11, 32'h2_0100_0_00, 32'h2_0100_0_00, 32'h2_0100_4_22,
                 32'h2_0100_4_44, 32'h2_1000_5_77, 32'h2_1000_5_77, 32'h0_0001_0_00};
        for (int i = 0; i < 12; i++) begin
            drive(stim[i]);
            tick();
            if (w_obs !== exp[i]) begin
                n_err++;
                $display("FAIL backpressure step %0d: got %h expected %h", i, w_obs, exp[i]);
            end
            n_vec++;
        end
    endtask

    task automatic test_zero_back_to_back();
        logic [15:0] stim [7];
        logic [31:0] exp [7];
        stim = '{16'h65A0, 16'h5000, 16'h4000, 16'h5001, 16'h5007, 16'h5007, 16'h4000};
        exp  = '{32'h0_0001_0_00, 32'h2_0010_6_00, 32'h2_1000_5_00, 32'h2_0010_6_01,
                 32'h2_0100_4_5A, 32'h2_1000_5_5A, 32'h0_0001_0_00};
        for (int i = 0; i < 7; i++) begin
            drive(stim[i]);
            tick();
            if (w_obs !== exp[i]) begin
                n_err++;
                $display("FAIL zero_b2b step %0d: got %h expected %h", i, w_obs, exp[i]);
            end
            n_vec++;
        end
    endtask

    task automatic test_fifo_full();
        logic [15:0] stim [17];
        logic [31:0] exp [17];
        stim = '{16'h6010, 16'h6020, 16'h6040, 16'h6080, 16'h6100, 16'h5004,
                 16'h4000, 16'h6EE0, 16'h4000, 16'h4000, 16'h4000, 16'h4000,
                 16'h5001, 16'h4000, 16'h6330, 16'h4000, 16'h4000};
        exp  = '{32'h0_0001_0_00, 32'h0_0001_0_00, 32'h0_0001_0_00, 32'h1_0001_0_00,
                 32'h1_0001_0_00, 32'h3_0010_6_04, 32'h3_0100_4_01, 32'h2_0100_4_02,
                 32'h2_0100_4_04, 32'h2_0100_4_08, 32'h2_1000_5_0F, 32'h0_0001_0_00,
                 32'h2_0010_6_01, 32'h2_0100_0_00, 32'h2_0100_4_33, 32'h2_1000_5_33,
                 32'h0_0001_0_00};
        for (int i = 0; i < 17; i++) begin
            drive(stim[i]);
            tick();
            if (w_obs !== exp[i]) begin
                n_err++;
                $display("FAIL fifo_full step %0d: got %h expected %h", i, w_obs, exp[i]);
            end
            n_vec++;
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [15:0] stim [12];
        logic [31:0] exp [12];
        stim = '{16'h6C10, 16'h6C20, 16'h6C30, 16'h5003, 16'h4000, 16'h4000,
                 16'hD005, 16'h5001, 16'h4000, 16'h6770, 16'h4000, 16'h4000};
        exp  = '{32'h0_0001_0_00, 32'h0_0001_0_00, 32'h0_0001_0_00, 32'h2_0010_6_03,
                 32'h2_0100_4_C1, 32'h2_0100_4_C2, 32'h0_0001_0_00, 32'h2_0010_6_01,
                 32'h2_0100_0_00, 32'h2_0100_4_77, 32'h2_1000_5_77, 32'h0_0001_0_00};
        for (int i = 0; i < 12; i++) begin
            drive(stim[i]);
            tick();
            if (w_obs !== exp[i]) begin
                n_err++;
                $display("FAIL reset_mid step %0d: got %h expected %h", i, w_obs, exp[i]);
            end
            n_vec++;
        end
    endtask

    initial begin
        drive(16'h8000);
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_back_to_back();
        test_fifo_full();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
